// File: rtl/mode_select_if.sv
// mode_select_if: groups the raw pushbuttons and the mux/dice drives of mode_select.
//   master: button source, observes the outputs (board / bench side)
//   slave : the controller, samples the buttons and drives sel, roll, mode_chg
interface mode_select_if;
  logic sel_btn;   // raw mode-select pushbutton, asynchronous, active-high
  logic roll_btn;  // raw roll pushbutton, asynchronous, active-high
  logic sel;       // mux select: 0 = dice throw, 1 = traffic lights
  logic roll;      // dice button drive, high while a roll is in progress
  logic mode_chg;  // one-cycle pulse on every change of sel

  modport master (
    output sel_btn,
    output roll_btn,
    input  sel,
    input  roll,
    input  mode_chg
  );

  modport slave (
    input  sel_btn,
    input  roll_btn,
    output sel,
    output roll,
    output mode_chg
  );
endinterface

// File: rtl/mode_select.sv
// mode_select: debounced mode/roll front end for the dice-or-traffic-lights mux.
// Latency: raw button change to FSM outputs is DEBOUNCE+2 cycles; timeout reverts after TIMEOUT cycles.
// Backpressure: none; pushbuttons are sampled every cycle and every output is a plain register.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset
//   bus.slave  sel_btn/roll_btn in (raw, asynchronous); sel/roll/mode_chg out (registered)
module mode_select #(
  parameter int DEBOUNCE = 4,   // stable synchronised samples needed to accept a level (>= 1)
  parameter int TIMEOUT  = 64   // idle cycles in DICE before reverting to LIGHTS (0 = never)
) (
  input  logic   clk,
  input  logic   rst,
  mode_select_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TO_MAX  = (TIMEOUT > 0) ? TW'(TIMEOUT)     : '0;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  // Button index: bit 0 = select, bit 1 = roll.
  localparam int B_SEL  = 0;
  localparam int B_ROLL = 1;

  typedef enum logic [1:0] {
    LIGHTS  = 2'd0,
    DICE    = 2'd1,
    ROLLING = 2'd2
  } state_t;

  logic [1:0]         sync_1;
  logic [1:0]         sync_2;
  logic [1:0]         deb;
  logic [1:0]         press;
  logic [1:0][CW-1:0] deb_cnt;

  state_t             state;
  logic [TW-1:0]      idle_cnt;
  logic               sel_q;
  logic               roll_q;
  logic               mode_chg_q;
  logic               timeout_hit;

  // --------------------------------------------------------------------------
  // Synchronisers and debouncers, one lane per button.
  // A level is accepted on the DEBOUNCE-th consecutive cycle of disagreement
  // between the synchronised and debounced values; any agreement restarts the
  // count, so shorter pulses never get through. The press strobe is loaded on
  // the same edge the debounced level rises, so the FSM sees it one cycle later.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1  <= '0;
      sync_2  <= '0;
      deb     <= '0;
      press   <= '0;
      deb_cnt <= '0;
    end else begin
      sync_1 <= {bus.roll_btn, bus.sel_btn};
      sync_2 <= sync_1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync_2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DB_LAST) begin
          deb[i]     <= sync_2[i];
          deb_cnt[i] <= '0;
          press[i]   <= sync_2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1);
        end
      end
    end
  end

  // The idle counter reads TIMEOUT-1 on the edge that is TIMEOUT cycles after
  // entering DICE, so leaving on that edge gives an exact TIMEOUT-cycle dwell.
  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == TO_LAST);

  // --------------------------------------------------------------------------
  // Mode FSM with registered outputs. Priority in DICE: select press, then
  // roll press, then timeout. A roll strobe arriving in LIGHTS (alone or with
  // a select press) is simply dropped; only a fresh press in DICE rolls.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LIGHTS;
      idle_cnt   <= '0;
      sel_q      <= 1'b1;
      roll_q     <= 1'b0;
      mode_chg_q <= 1'b0;
    end else begin
      mode_chg_q <= 1'b0;
      case (state)
        LIGHTS: begin
          idle_cnt <= '0;
          if (press[B_SEL]) begin
            state      <= DICE;
            sel_q      <= 1'b0;
            roll_q     <= 1'b0;
            mode_chg_q <= 1'b1;
          end
        end

        DICE: begin
          if (press[B_SEL]) begin
            state      <= LIGHTS;
            idle_cnt   <= '0;
            sel_q      <= 1'b1;
            mode_chg_q <= 1'b1;
          end else if (press[B_ROLL]) begin
            state    <= ROLLING;
            idle_cnt <= '0;
            roll_q   <= 1'b1;
          end else if (timeout_hit) begin
            state      <= LIGHTS;
            idle_cnt   <= '0;
            sel_q      <= 1'b1;
            mode_chg_q <= 1'b1;
          end else if (idle_cnt != TO_MAX) begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end

        ROLLING: begin
          // Release is level-based: the roll lasts as long as the debounced
          // button is held. Entering DICE again restarts the idle count.
          idle_cnt <= '0;
          if (!deb[B_ROLL]) begin
            state  <= DICE;
            roll_q <= 1'b0;
          end
        end

        default: begin
          state      <= LIGHTS;
          idle_cnt   <= '0;
          sel_q      <= 1'b1;
          roll_q     <= 1'b0;
          mode_chg_q <= ~sel_q;
        end
      endcase
    end
  end

  assign bus.sel      = sel_q;
  assign bus.roll     = roll_q;
  assign bus.mode_chg = mode_chg_q;

endmodule

// File: doc/mode_select.md
# mode_select

Front-end controller for the dice-or-traffic-lights exercise. Takes two raw, bouncing pushbuttons (mode select and roll), synchronises and debounces them, and drives the `sel` input of the downstream mux and the `button` input of the dice. It also handles an automatic return to traffic-lights mode after a period of inactivity in dice mode.

## Interface
Parameters:
- `DEBOUNCE`, default 4: consecutive stable synchronised samples required before a button level is accepted. Legal range is ≥1.
- `TIMEOUT`, default 64: cycles of inactivity in DICE before the block reverts to LIGHTS. 0 disables the timeout.

Ports (all synchronous to `clk`). One clock; reset is asynchronous and active-low.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `sel_btn` input 1: raw mode-select pushbutton, asynchronous, active-high.
- `roll_btn` input 1: raw roll pushbutton, asynchronous, active-high.
- `sel` output 1: mux select. 0 selects the dice throw; 1 selects the traffic lights.
- `roll` output 1: dice `button` drive. High while a roll is in progress.
- `mode_chg` output 1: one-cycle pulse on every change of `sel`.

## Operation
- **Synchroniser:** each raw button passes through its own 2-flop synchroniser, reset to 0.
- **Debounce:** there is one counter per button, of width $clog2(DEBOUNCE+1).
  - The counter increments each cycle the synchronised value differs from the debounced value.
  - It clears whenever they are equal.
  - When the count reaches DEBOUNCE-1 with a mismatch still present, the debounced value takes the synchronised value on that edge and the counter clears.
  - Pulses shorter than DEBOUNCE cycles are never accepted.
- **Press event:** a rising edge of a debounced level, registered as a one-cycle internal strobe.
- **FSM states:**
  - LIGHTS: `sel`=1, `roll`=0.
  - DICE: `sel`=0, `roll`=0.
  - ROLLING: `sel`=0, `roll`=1.
- **Transitions from LIGHTS:**
  - A select press moves to DICE.
  - A roll press is ignored.
- **Transitions from DICE:**
  - A select press moves to LIGHTS.
  - Otherwise a roll press moves to ROLLING.
  - Otherwise, when the idle counter reaches TIMEOUT (and TIMEOUT≠0), the block moves to LIGHTS.
- **Transitions from ROLLING:**
  - When the debounced roll level goes low, the block moves to DICE.
  - A select press is ignored.
- **Idle counter:**
  - Width is $clog2(TIMEOUT+1).
  - Cleared on entry to DICE, and held at 0 outside DICE.
  - Increments each cycle in DICE and saturates at TIMEOUT.
- **`mode_chg`:** registered; high for exactly the cycle after any `sel` change, including changes caused by the timeout.
- **Simultaneous events:**
  - Select and roll presses in the same cycle in DICE: select wins, go to LIGHTS.
  - Select and roll presses in the same cycle in LIGHTS: go to DICE; the roll is discarded and needs a fresh press.
  - A press in the same cycle the timeout expires: the press wins.
- **Reset (asynchronous assert, at any time including mid-roll):**
  - State is LIGHTS, with `sel`=1, `roll`=0 and `mode_chg`=0 immediately.
  - Synchronisers, debounced levels, counters and edge registers are cleared to 0.
- **Button held through reset release:** it is seen as a 0→1 change, debounced, and accepted as a new press.

## Timing
- **Latency:** a raw level change first sampled at edge N updates the debounced level at edge N+1+DEBOUNCE. The FSM output changes at edge N+2+DEBOUNCE. With DEBOUNCE=4 this is 6 cycles.
- **Release latency:** release from ROLLING to DICE has the same latency.
- **Timeout:** entry to DICE at edge M, with no presses, reverts to LIGHTS at edge M+TIMEOUT.
- **`mode_chg`:** asserted in the cycle after `sel` changes, and for one cycle only.
- **Outputs:** all are registered. There are no combinational paths from inputs to outputs.

## Test plan
1. **Reset and select press:** reset low for 2 cycles, then high; `sel_btn` held 1 for 10 cycles.
   - `sel`=1 and `roll`=0 during reset.
   - `sel` goes 1→0 exactly 6 cycles after first sampling.
   - `mode_chg` is a single pulse.
2. **Bounce rejection:** `sel_btn` toggled 1,0,1,0 on successive cycles, then 3-cycle pulses (DEBOUNCE=4).
   - `sel` never changes.
   - `mode_chg` stays 0.
3. **Roll sequence:** in DICE, `roll_btn` held 8 cycles, then released.
   - `roll` rises 6 cycles after press and falls 6 cycles after release.
   - `sel` stays 0 throughout.
   - A `sel_btn` press while ROLLING is ignored.
4. **Timeout:** enter DICE with TIMEOUT=64, then no presses.
   - `sel` returns to 1 exactly 64 cycles after entry, with a `mode_chg` pulse.
   - A roll press at cycle 30 restarts the count after release.
5. **Simultaneous presses:** in DICE, `sel_btn` and `roll_btn` rise on the same edge.
   - LIGHTS is reached.
   - `roll` is never asserted.
6. **Reset mid-roll:** `rst` asserted low while in ROLLING.
   - `roll`=0 and `sel`=1 immediately, asynchronously.
   - With `roll_btn` still held after release, the block stays in LIGHTS.
